booth_mult_seq: RTL and testbench

- Parametrised, multi-cycle radix-2 Booth multiplier. Successor to the fixed 4-bit free-running Booth block.
- Adds generic operand width, a signed/unsigned mode, and a start/busy/done handshake.
- Operands are latched on start. One Booth iteration (add/sub plus arithmetic shift) runs per clock.
- Sits in the datapath as a shared low-area multiplier for any requester that can wait WIDTH+1 cycles.

---
 rtl/booth_mult_seq.sv | 134 +++++++++++++
 tb/tb_booth_mult_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: multi-cycle radix-2 Booth multiplier with start/busy/done handshake.
// Operands are extended to WIDTH+1 bits so that both signed and unsigned
// ranges are exact; one add/sub + arithmetic shift is performed per clock.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     mr_in,
    input  logic [WIDTH-1:0]     md,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH:0]       r_a;
    logic [WIDTH:0]       r_q;
    logic [WIDTH:0]       r_m;
    logic                 r_qm1;
    logic [CW-1:0]        r_count;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_a_nxt;
    logic [WIDTH:0]       w_q_nxt;
    logic [WIDTH:0]       w_m_nxt;
    logic                 w_qm1_nxt;
    logic [CW-1:0]        w_count_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic [2*WIDTH-1:0]   w_out_nxt;

    // Booth recoding of {Q[0], q_m1}: add M, subtract M, or keep A (mod 2^(WIDTH+1)).
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    // Next-state and next-datapath logic: operand latch in IDLE, one iteration per RUN cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_q_nxt     = r_q;
        w_m_nxt     = r_m;
        w_qm1_nxt   = r_qm1;
        w_count_nxt = r_count;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_out_nxt   = out;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_m_nxt     = is_signed ? {md[WIDTH-1], md} : {1'b0, md};
                    w_q_nxt     = is_signed ? {mr_in[WIDTH-1], mr_in} : {1'b0, mr_in};
                    w_a_nxt     = '0;
                    w_qm1_nxt   = 1'b0;
                    w_count_nxt = CW'(WIDTH + 1);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // Arithmetic right shift of {A', Q, q_m1}, replicating the sign of A'.
                w_a_nxt     = {w_sum[WIDTH], w_sum[WIDTH:1]};
                w_q_nxt     = {w_sum[0], r_q[WIDTH:1]};
                w_qm1_nxt   = r_q[0];
                w_count_nxt = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    // Low 2*WIDTH bits of the post-shift {A, Q}.
                    w_out_nxt   = {w_a_nxt[WIDTH-2:0], w_q_nxt};
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
        end else begin
            r_a     <= w_a_nxt;
            r_q     <= w_q_nxt;
            r_m     <= w_m_nxt;
            r_qm1   <= w_qm1_nxt;
            r_count <= w_count_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            out     <= w_out_nxt;
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH = 4, 8 and 16.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        s4_start = 1'b0, s4_sgn = 1'b0, s4_busy, s4_done;
    logic [3:0]  s4_mr = 4'd0, s4_md = 4'd0;
    logic [7:0]  s4_out;

    logic        s8_start = 1'b0, s8_sgn = 1'b0, s8_busy, s8_done;
    logic [7:0]  s8_mr = 8'd0, s8_md = 8'd0;
    logic [15:0] s8_out;

    logic        s16_start = 1'b0, s16_sgn = 1'b0, s16_busy, s16_done;
    logic [15:0] s16_mr = 16'd0, s16_md = 16'd0;
    logic [31:0] s16_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(s4_start), .is_signed(s4_sgn),
        .mr_in(s4_mr), .md(s4_md), .busy(s4_busy), .done(s4_done), .out(s4_out));

    booth_mult_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(s8_start), .is_signed(s8_sgn),
        .mr_in(s8_mr), .md(s8_md), .busy(s8_busy), .done(s8_done), .out(s8_out));

    booth_mult_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(s16_start), .is_signed(s16_sgn),
        .mr_in(s16_mr), .md(s16_md), .busy(s16_busy), .done(s16_done), .out(s16_out));

    // Reference product: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic s);
        longint x, y, p;
        longint mask;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        mask = (longint'(1) << (2 * w)) - longint'(1);
        return 64'(p & mask);
    endfunction

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_busy(input int w);
        if (w == 4) return s4_busy;
        else if (w == 8) return s8_busy;
        else return s16_busy;
    endfunction

    function automatic logic cur_done(input int w);
        if (w == 4) return s4_done;
        else if (w == 8) return s8_done;
        else return s16_done;
    endfunction

    function automatic logic [63:0] cur_out(input int w);
        if (w == 4) return 64'(s4_out);
        else if (w == 8) return 64'(s8_out);
        else return 64'(s16_out);
    endfunction

    // Pulse start on the chosen instance and wait (bounded) for done.
    // Returns the edge index of done (0 on timeout), busy-cycle count and product.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output int done_cyc, output int busy_cyc,
                          output logic [63:0] prod);
        if (w == 4) begin s4_mr = a[3:0]; s4_md = b[3:0]; s4_sgn = s; s4_start = 1'b1; end
        else if (w == 8) begin s8_mr = a[7:0]; s8_md = b[7:0]; s8_sgn = s; s8_start = 1'b1; end
        else begin s16_mr = a[15:0]; s16_md = b[15:0]; s16_sgn = s; s16_start = 1'b1; end
        step();
        s4_start = 1'b0; s8_start = 1'b0; s16_start = 1'b0;
        done_cyc = 0;
        busy_cyc = 0;
        prod     = 64'd0;
        for (int i = 1; i <= 40; i++) begin
            if (cur_busy(w)) busy_cyc++;
            step();
            if (cur_done(w)) begin
                done_cyc = i;
                prod     = cur_out(w);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_w8: busy=%b done=%b out=%h, want 0 0 0000", s8_busy, s8_done, s8_out);
        end
        n_checks++;
        if (s4_out !== 8'h00 || s16_out !== 32'h0 || s4_busy !== 1'b0 || s16_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_w4_w16: out4=%h out16=%h busy4=%b busy16=%b, want zeros",
                     s4_out, s16_out, s4_busy, s16_busy);
        end
    endtask

    task automatic test_basic_w4();
        int dc, bc;
        logic [63:0] p;
        run_op(4, 32'h7, 32'h5, 1'b1, dc, bc, p);
        n_checks++;
        if (dc !== 5 || bc !== 5) begin
            n_fail++;
            $display("FAIL w4_timing: done_cycle=%0d busy_cycles=%0d, want 5 5", dc, bc);
        end
        n_checks++;
        if (p[7:0] !== 8'h23) begin
            n_fail++;
            $display("FAIL w4_product: out=%h, want 23", p[7:0]);
        end
    endtask

    task automatic test_directed_w8();
        logic [7:0] ta [4] = '{8'hFD, 8'h80, 8'hFF, 8'hFF};
        logic [7:0] tb [4] = '{8'h05, 8'h80, 8'hFF, 8'hFF};
        logic       ts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] te [4] = '{16'hFFF1, 16'h4000, 16'hFE01, 16'h0001};
        int dc, bc;
        logic [63:0] p;
        for (int k = 0; k < 4; k++) begin
            run_op(8, 32'(ta[k]), 32'(tb[k]), ts[k], dc, bc, p);
            n_checks++;
            if (dc !== 9 || p[15:0] !== te[k]) begin
                n_fail++;
                $display("FAIL w8_directed_%0d: done_cycle=%0d out=%h, want 9 %h", k, dc, p[15:0], te[k]);
            end
            step();
            n_checks++;
            if (s8_done !== 1'b0 || s8_out !== te[k]) begin
                n_fail++;
                $display("FAIL w8_after_done_%0d: done=%b out=%h, want 0 %h", k, s8_done, s8_out, te[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int first_at;
        n_done = 0;
        first_at = 0;
        s8_mr = 8'd6; s8_md = 8'd7; s8_sgn = 1'b0; s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) begin
                s8_mr = 8'd9; s8_md = 8'd9; s8_sgn = 1'b1; s8_start = 1'b1;
            end else if (i == 4) begin
                s8_start = 1'b0;
            end
            step();
            if (s8_done) begin n_done++; if (first_at == 0) first_at = i; end
        end
        n_checks++;
        if (n_done !== 1 || first_at !== 9 || s8_out !== 16'h002A) begin
            n_fail++;
            $display("FAIL b2b_first: dones=%0d at=%0d out=%h, want 1 9 002A", n_done, first_at, s8_out);
        end
        // done is high now: accept 9x9 with zero idle cycles.
        s8_mr = 8'd9; s8_md = 8'd9; s8_sgn = 1'b0; s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        n_checks++;
        if (s8_busy !== 1'b1 || s8_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", s8_busy, s8_done);
        end
        n_done = 0;
        first_at = 0;
        for (int i = 1; i <= 9; i++) begin
            if (i < 9 && s8_out !== 16'h002A) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_hold: cycle=%0d out=%h, want 002A", i, s8_out);
            end
            step();
            if (s8_done) begin n_done++; if (first_at == 0) first_at = i; end
        end
        n_checks++;
        if (n_done !== 1 || first_at !== 9 || s8_out !== 16'h0051) begin
            n_fail++;
            $display("FAIL b2b_second: dones=%0d at=%0d out=%h, want 1 9 0051", n_done, first_at, s8_out);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int n_done;
        int dc, bc;
        logic [63:0] p;
        n_done = 0;
        s8_mr = 8'd100; s8_md = 8'd100; s8_sgn = 1'b0; s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (s8_done) n_done++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (s8_busy !== 1'b0 || s8_out !== 16'h0000 || s8_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b done=%b out=%h, want 0 0 0000", s8_busy, s8_done, s8_out);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            if (s8_done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: done pulses=%0d, want 0", n_done);
        end
        run_op(8, 32'd2, 32'd3, 1'b0, dc, bc, p);
        n_checks++;
        if (dc !== 9 || p[15:0] !== 16'h0006) begin
            n_fail++;
            $display("FAIL abort_restart: done_cycle=%0d out=%h, want 9 0006", dc, p[15:0]);
        end
    endtask

    task automatic test_random();
        int dc, bc;
        logic [63:0] p, e;
        logic [31:0] a, b;
        logic s;
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (k == 0) a = 32'd0;
            a = {24'd0, a[7:0]};
            b = {24'd0, b[7:0]};
            e = ref_prod(8, a, b, s);
            run_op(8, a, b, s, dc, bc, p);
            n_checks++;
            if (dc !== 9 || bc !== 9 || p[15:0] !== e[15:0]) begin
                n_fail++;
                $display("FAIL rand_w8_%0d: a=%h b=%h s=%b done_cycle=%0d busy=%0d out=%h, want 9 9 %h",
                         k, a[7:0], b[7:0], s, dc, bc, p[15:0], e[15:0]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            a = {28'd0, 4'($urandom)};
            b = {28'd0, 4'($urandom)};
            s = 1'(k);
            e = ref_prod(4, a, b, s);
            run_op(4, a, b, s, dc, bc, p);
            n_checks++;
            if (dc !== 5 || p[7:0] !== e[7:0]) begin
                n_fail++;
                $display("FAIL rand_w4_%0d: a=%h b=%h s=%b done_cycle=%0d out=%h, want 5 %h",
                         k, a[3:0], b[3:0], s, dc, p[7:0], e[7:0]);
            end
        end
    endtask

    task automatic test_w16();
        int dc, bc;
        logic [63:0] p, e;
        logic [31:0] a, b;
        run_op(16, 32'h8000, 32'h7FFF, 1'b1, dc, bc, p);
        n_checks++;
        if (dc !== 17 || p[31:0] !== 32'hC0008000) begin
            n_fail++;
            $display("FAIL w16_directed: done_cycle=%0d out=%h, want 17 C0008000", dc, p[31:0]);
        end
        step();
        n_checks++;
        if (s16_done !== 1'b0) begin
            n_fail++;
            $display("FAIL w16_done_width: done=%b one cycle later, want 0", s16_done);
        end
        for (int k = 0; k < 4; k++) begin
            a = {16'd0, 16'($urandom)};
            b = {16'd0, 16'($urandom)};
            e = ref_prod(16, a, b, k[0]);
            run_op(16, a, b, k[0], dc, bc, p);
            n_checks++;
            if (dc !== 17 || p[31:0] !== e[31:0]) begin
                n_fail++;
                $display("FAIL rand_w16_%0d: a=%h b=%h done_cycle=%0d out=%h, want 17 %h",
                         k, a[15:0], b[15:0], dc, p[31:0], e[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_w4();
        test_directed_w8();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_w16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
